// File: rtl/program_loader.sv
// Streams a little-endian byte image into instruction memory one 32-bit word at a time,
// holding the processor in reset until every requested word has been written.
module program_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   n_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]    IDLE_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERROR
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   word_addr_q, word_addr_d;
  logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]        idle_cnt_q, idle_cnt_d;
  logic [31:0]             word_q, word_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]             imem_wdata_q, imem_wdata_d;
  logic [ADDR_WIDTH:0]     n_clamped;
  logic                    byte_accept;

  assign n_clamped   = (n_words > MAX_WORDS) ? MAX_WORDS : n_words;
  assign byte_accept = (state_q == S_LOAD) && byte_valid;

  // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    word_addr_d  = word_addr_q;
    last_addr_d  = last_addr_q;
    byte_idx_d   = byte_idx_q;
    idle_cnt_d   = idle_cnt_q;
    word_d       = word_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          if (n_words == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_LOAD;
            word_addr_d = '0;
            byte_idx_d  = '0;
            idle_cnt_d  = '0;
            last_addr_d = ADDR_WIDTH'(n_clamped - 1'b1);
          end
        end
      end
      S_LOAD: begin
        if (byte_accept) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          idle_cnt_d = '0;
          if (byte_idx_q == 2'd3) begin
            // Capture the finished word so imem_addr/imem_wdata hold it after the strobe.
            state_d      = S_WRITE;
            imem_addr_d  = word_addr_q;
            imem_wdata_d = word_d;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d = S_ERROR;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (word_addr_q == last_addr_q) begin
          state_d = S_DONE;
        end else begin
          state_d     = S_LOAD;
          word_addr_d = word_addr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      word_addr_q  <= '0;
      last_addr_q  <= '0;
      byte_idx_q   <= '0;
      idle_cnt_q   <= '0;
      word_q       <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      word_addr_q  <= word_addr_d;
      last_addr_q  <= last_addr_d;
      byte_idx_q   <= byte_idx_d;
      idle_cnt_q   <= idle_cnt_d;
      word_q       <= word_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign byte_ready = (state_q == S_LOAD);
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign cpu_reset  = (state_q != S_DONE);

endmodule
